// File: rtl/ysyx_22040895_ifu_pf.sv
// Decoupled prefetching instruction-fetch unit: sequential imem requests, in-order
// responses buffered in a DEPTH-entry queue, redirect flushes and restarts fetch.
module ysyx_22040895_ifu_pf #(
  parameter int              XLEN     = 64,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h80000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW:0]   CREDIT_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [CW-1:0]     r_occ;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [XLEN-1:0]   r_q_pc   [DEPTH];
  logic [INST_W-1:0] r_q_inst [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outstanding_next;

  // Requests are only issued when a queue slot is reserved for the response.
  assign w_credit           = {1'b0, r_occ} + {1'b0, r_outstanding};
  assign imem_req_valid     = !rst && !redirect_valid && (w_credit < CREDIT_C);
  assign imem_req_addr      = r_fetch_pc;
  assign w_fire             = imem_req_valid && imem_req_ready;
  assign w_push             = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);
  assign out_valid          = (r_occ != '0) && !redirect_valid;
  assign w_pop              = out_valid && out_ready;
  assign out_pc             = r_q_pc[r_rd_ptr];
  assign out_inst           = r_q_inst[r_rd_ptr];
  assign w_outstanding_next = r_outstanding + CW'(w_fire) - CW'(imem_resp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_occ         <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= redirect_pc;
      r_rsp_pc      <= redirect_pc;
      r_occ         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= r_outstanding - CW'(imem_resp_valid);
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (imem_resp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      r_occ         <= r_occ + CW'(w_push) - CW'(w_pop);
      r_outstanding <= w_outstanding_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
      r_q_inst[r_wr_ptr] <= imem_resp_data;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_occ == FULL_C)));

endmodule

// File: tb/tb_ysyx_22040895_ifu_pf.sv
// Scoreboard bench for the prefetching fetch unit: behavioural memory with random
// latency, expected {pc, inst} queue filled at request time and drained on pops.
module tb_ysyx_22040895_ifu_pf;
  localparam int          XLEN     = 64;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [XLEN-1:0]   out_pc;

  ysyx_22040895_ifu_pf #(
    .XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct { longint due; logic [63:0] addr; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;

  mreq_t mq[$];
  exp_t  sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_due = -1;
  int     rdy_pct = 100, ordy_pct = 100, lat_min = 1, lat_max = 1;
  bit          redir_now = 1'b0;
  logic [63:0] redir_target = '0;
  logic [63:0] m_fetch;
  int          m_occ, m_out, m_drop;
  int          fires = 0, pops = 0, p0;
  logic [63:0] last_pop_pc = '0;
  bit          saw_wrap = 1'b0;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    sb.delete();
    m_fetch  = RESET_PC;
    m_occ    = 0;
    m_out    = 0;
    m_drop   = 0;
    last_due = cyc;
  endtask

  // One clock: drive at negedge, sample 1ns later, update model for the next posedge.
  task automatic step();
    bit    fire, pop, resp, exp_rv, exp_ov;
    exp_t  e;
    mreq_t r;
    int     lat;
    longint due;
    @(negedge clk);
    imem_req_ready  = ($urandom_range(99) < rdy_pct);
    out_ready       = ($urandom_range(99) < ordy_pct);
    redirect_valid  = redir_now;
    redirect_pc     = redir_target;
    redir_now       = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_f(r.addr);
    end
    #1;
    exp_rv = !redirect_valid && (m_occ + m_out < DEPTH);
    exp_ov = (m_occ != 0) && !redirect_valid;
    check_val("req_valid", 96'(imem_req_valid), 96'(exp_rv));
    check_val("out_valid", 96'(out_valid), 96'(exp_ov));
    fire = imem_req_valid && imem_req_ready;
    pop  = out_valid && out_ready;
    resp = imem_resp_valid;
    if (fire) begin
      check_val("req_addr", 96'(imem_req_addr), 96'(m_fetch));
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{due, imem_req_addr});
      last_due = due;
      fires++;
    end
    if (pop) begin
      $display("pop cyc=%0d pc=%h inst=%h", cyc, out_pc, out_inst);
      if (sb.size() == 0) begin
        check_val("pop_has_expected", 96'(sb.size()), 96'(1));
      end else begin
        e = sb.pop_front();
        check_val("out_pc_inst", {out_pc, out_inst}, {e.pc, e.inst});
      end
      pops++;
      last_pop_pc = out_pc;
      if (out_pc == 64'h0) saw_wrap = 1'b1;
    end
    if (redirect_valid) begin
      m_drop  = m_out - int'(resp);
      m_occ   = 0;
      m_fetch = redirect_pc;
      sb.delete();
    end else begin
      if (resp) begin
        if (m_drop != 0) m_drop--;
        else m_occ++;
      end
      if (pop) m_occ--;
      if (fire) begin
        sb.push_back('{m_fetch, mem_f(m_fetch)});
        m_fetch += 64'd4;
      end
    end
    m_out = m_out + int'(fire) - int'(resp);
    cyc++;
  endtask

  task automatic quiet_inputs();
    imem_req_ready  = 1'b0;
    out_ready       = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    reset_model();
    repeat (3) @(negedge clk);
    check_val("rst_req_valid", 96'(imem_req_valid), 96'(0));
    check_val("rst_out_valid", 96'(out_valid), 96'(0));
    check_val("rst_out_pc_inst", {out_pc, out_inst}, 96'(0));
    check_val("rst_req_addr", 96'(imem_req_addr), 96'(RESET_PC));
    rst = 1'b0;

    // Streaming at full rate: one delivery per cycle after a 2-cycle fill.
    repeat (3) step();
    pops = 0;
    repeat (20) step();
    check_val("t1_throughput", 96'(pops), 96'(20));

    // Redirect colliding with a response and a would-be pop.
    redir_now = 1'b1; redir_target = 64'h8000_2000;
    step();
    step();

    // Asynchronous reset between edges with requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (6) step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_req_valid", 96'(imem_req_valid), 96'(0));
    check_val("async_rst_out_valid", 96'(out_valid), 96'(0));
    quiet_inputs();
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Backpressure: credits stop fetch at DEPTH, then drain in order.
    lat_min = 1; lat_max = 1; ordy_pct = 0;
    fires = 0;
    repeat (10) step();
    check_val("t2_fires", 96'(fires), 96'(4));
    ordy_pct = 100;
    pops = 0;
    repeat (4) step();
    check_val("t2_pops", 96'(pops), 96'(4));

    // Redirect with long-latency responses in flight.
    lat_min = 4; lat_max = 4;
    repeat (6) step();
    redir_now = 1'b1; redir_target = 64'h8000_1000;
    step();
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) step();
    check_val("t3_first_pc", 96'(last_pop_pc), 96'(64'h8000_1000));

    // Address wrap modulo 2^XLEN.
    lat_min = 1; lat_max = 1;
    redir_now = 1'b1; redir_target = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    repeat (12) step();
    check_val("wrap_seen", 96'(saw_wrap), 96'(1));

    // Back-to-back redirects: last one wins.
    redir_now = 1'b1; redir_target = 64'h8000_3000;
    step();
    redir_now = 1'b1; redir_target = 64'h8000_4000;
    step();
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) step();
    check_val("b2b_first_pc", 96'(last_pop_pc), 96'(64'h8000_4000));

    // Random traffic with occasional redirects.
    rdy_pct = 60; ordy_pct = 70; lat_min = 1; lat_max = 5;
    pops = 0;
    for (int i = 0; i < 70000 && pops < 10000; i++) begin
      if ($urandom_range(49) == 0) begin
        redir_now    = 1'b1;
        redir_target = {$urandom, $urandom} & ~64'h3;
      end
      step();
    end
    check_val("random_delivered", 96'(pops >= 10000), 96'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
